// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions used by the fetch stage.
package mips_pkg;

   // Encoding of sll $0,$0,0: the bubble placed in the decode register.
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   // One fetched instruction together with the PC+4 of its address.
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pcplus4;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between fetch and the imem.
interface fetch_stage_if;

   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;

   // Fetch side issues requests and consumes in-order responses.
   modport master (
      output imem_req,
      output imem_addr,
      input  imem_gnt,
      input  imem_rvalid,
      input  imem_rdata
   );

   // Memory side accepts requests and returns responses.
   modport slave (
      input  imem_req,
      input  imem_addr,
      output imem_gnt,
      output imem_rvalid,
      output imem_rdata
   );

endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO with clear; DEPTH must be a power of two.
module fetch_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   clear,
   input  logic                   push,
   input  logic [WIDTH-1:0]       pushData,
   input  logic                   pop,
   output logic [WIDTH-1:0]       headData,
   output logic [$clog2(DEPTH):0] count,
   output logic                   empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    rdPtr;
   logic [PW-1:0]    wrPtr;
   logic             doPush;
   logic             doPop;

   // Clear takes priority over any push or pop in the same cycle.
   assign empty    = (count == '0);
   assign doPush   = push && !clear && (count != FULL_COUNT);
   assign doPop    = pop && !clear && !empty;
   assign headData = mem[rdPtr];

   // Pointer and occupancy bookkeeping; pointers wrap naturally.
   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else if (clear) begin
         rdPtr <= '0;
         wrPtr <= '0;
         count <= '0;
      end else begin
         if (doPush) wrPtr <= wrPtr + PW'(1);
         if (doPop)  rdPtr <= rdPtr + PW'(1);
         count <= count + CW'(doPush) - CW'(doPop);
      end
   end

   // Entry storage.
   // NOTE: storage is not reset; an entry is only read after it has been written, so a reset would only cost flops.
   always_ff @(posedge clk) begin
      if (doPush) mem[wrPtr] <= pushData;
   end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage plus IF/ID register.
// Build option: define FETCH_BYPASS_EN to let a response load the decode
// register directly when the instruction buffer is empty.
module fetch_stage
   import mips_pkg::*;
#(
   parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
   parameter int          DEPTH    = 2
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stallD,
   input  logic                flushD,
   input  logic                pcsrcD,
   input  logic [31:0]         pcbranchD,
   input  logic                jumpD,
   input  logic [31:0]         pcjumpD,
   fetch_stage_if.master       imem,
   output logic [31:0]         instrD,
   output logic [31:0]         pcplus4D,
   output logic                validD
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW:0] SUM_LIMIT = (CW + 1)'(DEPTH);

   logic [31:0]   pc;
   logic [CW-1:0] dropCnt;
   logic [CW-1:0] tagCount;     // requests granted but not yet answered
   logic          tagEmpty;
   logic [31:0]   tagHead;      // PC+4 belonging to the oldest in-flight request
   logic [CW-1:0] bufCount;
   logic          bufEmpty;
   fetch_entry_t  bufHead;
   fetch_entry_t  rspEntry;
   logic          reqFire;
   logic          rspFire;
   logic          rspKeep;
   logic          bypassTake;
   logic          redirect;
   logic          bufPop;
   logic [CW-1:0] outstandingNext;

   // Throttle so every granted request is guaranteed a buffer slot.
   assign imem.imem_req  = reset && (({1'b0, bufCount} + {1'b0, tagCount}) < SUM_LIMIT);
   assign imem.imem_addr = pc;

   assign reqFire  = imem.imem_req && imem.imem_gnt;
   // A response with nothing in flight is a protocol error and is ignored.
   assign rspFire  = imem.imem_rvalid && !tagEmpty;
   assign rspKeep  = rspFire && (dropCnt == '0);
   assign redirect = (pcsrcD || jumpD) && !stallD;
   assign bufPop   = !stallD && !flushD && !bufEmpty;
   assign rspEntry = '{instr: imem.imem_rdata, pcplus4: tagHead};

   assign outstandingNext = tagCount + CW'(reqFire) - CW'(rspFire);

`ifdef FETCH_BYPASS_EN
   assign bypassTake = rspKeep && bufEmpty && !stallD && !flushD;
`else
   assign bypassTake = 1'b0;
`endif

   fetch_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_tagFifo (
      .clk      (clk),
      .reset    (reset),
      .clear    (1'b0),
      .push     (reqFire),
      .pushData (pc + 32'd4),
      .pop      (rspFire),
      .headData (tagHead),
      .count    (tagCount),
      .empty    (tagEmpty)
   );

   fetch_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_instrBuf (
      .clk      (clk),
      .reset    (reset),
      .clear    (redirect),
      .push     (rspKeep && !bypassTake),
      .pushData (rspEntry),
      .pop      (bufPop),
      .headData (bufHead),
      .count    (bufCount),
      .empty    (bufEmpty)
   );

   // PC advance/redirect and the count of stale responses still to discard.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc      <= RESET_PC;
         dropCnt <= '0;
      end else if (redirect) begin
         pc      <= jumpD ? pcjumpD : pcbranchD;
         dropCnt <= outstandingNext;
      end else begin
         if (reqFire) pc <= pc + 32'd4;
         if (rspFire && (dropCnt != '0)) dropCnt <= dropCnt - CW'(1);
      end
   end

   // IF/ID register: flush wins over stall, otherwise pop, bypass or bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         instrD   <= NOP_INSTR;
         pcplus4D <= '0;
         validD   <= 1'b0;
      end else if (flushD) begin
         instrD   <= NOP_INSTR;
         pcplus4D <= '0;
         validD   <= 1'b0;
      end else if (!stallD) begin
         if (!bufEmpty) begin
            instrD   <= bufHead.instr;
            pcplus4D <= bufHead.pcplus4;
            validD   <= 1'b1;
         end else if (bypassTake) begin
            instrD   <= rspEntry.instr;
            pcplus4D <= rspEntry.pcplus4;
            validD   <= 1'b1;
         end else begin
            instrD   <= NOP_INSTR;
            pcplus4D <= '0;
            validD   <= 1'b0;
         end
      end
   end

   // Flag responses that arrive with no request in flight.
   always_ff @(posedge clk) begin
      if (reset && imem.imem_rvalid)
         assert (!tagEmpty) else $error("fetch_stage: imem_rvalid with no outstanding request");
   end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a queue-based in-order memory model.
module tb_fetch_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic        stallD, flushD, pcsrcD, jumpD;
   logic [31:0] pcbranchD, pcjumpD;
   logic [31:0] instrD, pcplus4D;
   logic        validD;

   fetch_stage_if bus ();

   fetch_stage #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
      .clk       (clk),
      .reset     (reset),
      .stallD    (stallD),
      .flushD    (flushD),
      .pcsrcD    (pcsrcD),
      .pcbranchD (pcbranchD),
      .jumpD     (jumpD),
      .pcjumpD   (pcjumpD),
      .imem      (bus),
      .instrD    (instrD),
      .pcplus4D  (pcplus4D),
      .validD    (validD)
   );

   always #5 clk = ~clk;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] memQ[$];
   logic        memHold = 1'b0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
      total++;
      assert (got === want) else begin
         bad++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   // One clock: sample the request at negedge, then answer from the queue after the edge.
   task automatic tick();
      logic        fire;
      logic [31:0] addr;
      @(negedge clk);
      fire = bus.imem_req && bus.imem_gnt;
      addr = bus.imem_addr;
      @(posedge clk);
      #1;
      if (fire) memQ.push_back(addr);
      if (!memHold && memQ.size() > 0) begin
         bus.imem_rvalid = 1'b1;
         bus.imem_rdata  = memQ.pop_front() >> 2;
      end else begin
         bus.imem_rvalid = 1'b0;
         bus.imem_rdata  = '0;
      end
   endtask

   // Advance until the decode register holds a real instruction, then compare it.
   task automatic expectNext(input string tag, input logic [31:0] wantInstr, input logic [31:0] wantPc4);
      int waited = 0;
      do begin
         tick();
         waited++;
      end while (validD !== 1'b1 && waited < 20);
      total++;
      assert (validD === 1'b1 && instrD === wantInstr && pcplus4D === wantPc4) else begin
         bad++;
         $error("FAIL %s: observed valid=%b instr=%h pc4=%h expected valid=1 instr=%h pc4=%h",
                tag, validD, instrD, pcplus4D, wantInstr, wantPc4);
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset = 1'b0;
      stallD = 1'b0; flushD = 1'b0; pcsrcD = 1'b0; jumpD = 1'b0;
      pcbranchD = '0; pcjumpD = '0;
      bus.imem_gnt = 1'b1; bus.imem_rvalid = 1'b0; bus.imem_rdata = '0;

      // Reset state
      tick(); tick();
      check("rst_instr", instrD, 32'h0);
      check("rst_pc4", pcplus4D, 32'h0);
      check("rst_valid", {31'b0, validD}, 32'h0);
      check("rst_req", {31'b0, bus.imem_req}, 32'h0);

      // Release: first request at RESET_PC, first valid after third edge
      reset = 1'b1;
      #1;
      check("rel_req", {31'b0, bus.imem_req}, 32'h1);
      check("rel_addr", bus.imem_addr, 32'h0);
      tick();
      check("e0_valid", {31'b0, validD}, 32'h0);
      check("e0_addr", bus.imem_addr, 32'h4);
      tick();
      check("e1_valid", {31'b0, validD}, 32'h0);
      tick();
      check("e2_valid", {31'b0, validD}, 32'h1);
      check("e2_instr", instrD, 32'h0);
      check("e2_pc4", pcplus4D, 32'h4);
      expectNext("seq1", 32'h1, 32'h8);
      expectNext("seq2", 32'h2, 32'hc);
      expectNext("seq3", 32'h3, 32'h10);

      // Stall 3 cycles: decode frozen, requests throttled once buffer fills
      stallD = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check("stall_instr", instrD, 32'h3);
         check("stall_pc4", pcplus4D, 32'h10);
      end
      check("stall_req", {31'b0, bus.imem_req}, 32'h0);
      stallD = 1'b0;
      expectNext("post_stall4", 32'h4, 32'h14);
      expectNext("post_stall5", 32'h5, 32'h18);
      expectNext("post_stall6", 32'h6, 32'h1c);

      // Branch with two responses held in flight
      memHold = 1'b1;
      for (int i = 0; i < 4; i++) tick();
      check("hold_req", {31'b0, bus.imem_req}, 32'h0);
      memHold = 1'b0;
      pcsrcD = 1'b1; pcbranchD = 32'h100;
      tick();
      pcsrcD = 1'b0;
      check("br_addr", bus.imem_addr, 32'h100);
      check("br_valid", {31'b0, validD}, 32'h0);
      expectNext("br_first", 32'h40, 32'h104);

      // Jump and branch together: jump wins
      jumpD = 1'b1; pcsrcD = 1'b1; flushD = 1'b1;
      pcjumpD = 32'h200; pcbranchD = 32'h100;
      tick();
      jumpD = 1'b0; pcsrcD = 1'b0; flushD = 1'b0;
      check("jmp_addr", bus.imem_addr, 32'h200);
      check("jmp_valid", {31'b0, validD}, 32'h0);
      expectNext("jmp_first", 32'h80, 32'h204);
      expectNext("jmp_second", 32'h81, 32'h208);

      // Flush while stalled clears decode, buffer head survives
      stallD = 1'b1; flushD = 1'b1;
      tick();
      stallD = 1'b0; flushD = 1'b0;
      check("flush_instr", instrD, 32'h0);
      check("flush_valid", {31'b0, validD}, 32'h0);
      expectNext("flush_next", 32'h82, 32'h20c);

      // Reset mid-stream while a response is on the bus
      for (int i = 0; i < 10 && bus.imem_rvalid !== 1'b1; i++) tick();
      check("pre_rst_rvalid", {31'b0, bus.imem_rvalid}, 32'h1);
      reset = 1'b0;
      #1;
      check("mid_rst_instr", instrD, 32'h0);
      check("mid_rst_pc4", pcplus4D, 32'h0);
      check("mid_rst_valid", {31'b0, validD}, 32'h0);
      check("mid_rst_req", {31'b0, bus.imem_req}, 32'h0);
      tick(); tick(); tick();
      reset = 1'b1;
      #1;
      check("rerel_req", {31'b0, bus.imem_req}, 32'h1);
      check("rerel_addr", bus.imem_addr, 32'h0);
      expectNext("rerel_first", 32'h0, 32'h4);
      expectNext("rerel_second", 32'h1, 32'h8);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
